// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group is
// resolved per stage, with the inter-group carry registered between stages.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  // Carries of one group as flattened sums of products; no c[i] feeds c[i+1].
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             c0);
    logic [GROUP:0] c;
    logic           acc;
    logic           pp;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & c0);
    end
    return c;
  endfunction

  logic             stall;
  logic             en;
  logic [WIDTH-1:0] a_w [NG];
  logic [WIDTH-1:0] b_w [NG];
  logic [WIDTH-1:0] s_w [NG+1];
  logic             c_w [NG+1];
  logic             v_w [NG+1];

  // A stalled output freezes the whole pipe, bubbles included.
  assign stall    = v_w[NG] && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  assign a_w[0] = a;
  assign b_w[0] = sub ? ~b : b;
  assign s_w[0] = '0;
  assign c_w[0] = sub ? 1'b1 : cin;
  assign v_w[0] = in_valid;

  assign out_valid = v_w[NG];
  assign sum       = s_w[NG];
  assign cout      = c_w[NG];

  for (genvar k = 0; k < NG; k++) begin : g_stage
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             vld_q;

    always_comb begin
      p   = a_w[k][k*GROUP +: GROUP] ^ b_w[k][k*GROUP +: GROUP];
      g   = a_w[k][k*GROUP +: GROUP] & b_w[k][k*GROUP +: GROUP];
      c   = cla_carries(p, g, c_w[k]);
      s_d = s_w[k];
      s_d[k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
    end

    // Stage k register: resolved sum bits, group carry-out and valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        c_q   <= 1'b0;
      end else if (en) begin
        vld_q <= v_w[k];
        s_q   <= s_d;
        c_q   <= c[GROUP];
      end
    end

    assign s_w[k+1] = s_q;
    assign c_w[k+1] = c_q;
    assign v_w[k+1] = vld_q;

    if (k < NG - 1) begin : g_pass
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk) begin
        if (en) begin
          a_q <= a_w[k];
          b_q <= b_w[k];
        end
      end

      assign a_w[k+1] = a_q;
      assign b_w[k+1] = b_q;
    end

    if (k == NG - 1) begin : g_flag
      logic ovf_q;

      // Carry into the MSB differs from carry out of it on signed overflow.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c[GROUP] ^ c[GROUP-1];
        end
      end

      assign ovf = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed table, backpressure,
// mid-flight reset, and a single-stage (NG=1) instance.
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        n1_in_valid, n1_in_ready, n1_cin, n1_sub, n1_out_valid, n1_cout, n1_ovf;
  logic [3:0]  n1_a, n1_b, n1_sum;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  exp_t q[$];
  bit   saw_bp = 1'b0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .a(n1_a), .b(n1_b), .cin(n1_cin), .sub(n1_sub), .out_valid(n1_out_valid),
    .out_ready(1'b1), .sum(n1_sum), .cout(n1_cout), .ovf(n1_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tc, input logic ts);
    exp_t        e;
    logic [16:0] f;
    if (ts) begin
      e.s = ta - tb;
      e.c = (ta >= tb);
      e.o = (ta[15] != tb[15]) && (e.s[15] != ta[15]);
    end else begin
      f   = {1'b0, ta} + {1'b0, tb} + {16'b0, tc};
      e.s = f[15:0];
      e.c = f[16];
      e.o = (ta[15] == tb[15]) && (e.s[15] != ta[15]);
    end
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                      input logic tc, input logic ts, input exp_t e);
    bit done;
    done     = 1'b0;
    a        = ta;
    b        = tb;
    cin      = tc;
    sub      = ts;
    in_valid = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc + 1;
        q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 60 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard and protocol monitor on the falling edge.
  initial begin
    bit          prev_stall;
    logic [15:0] ps;
    logic        pc, po;
    exp_t        e;
    prev_stall = 1'b0;
    ps = '0; pc = 1'b0; po = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
      end else begin
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
          saw_bp = 1'b1;
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_sum", sum, ps);
          chk("stall_cout", cout, pc);
          chk("stall_ovf", ovf, po);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got sum=%h, expected no result", sum);
          end else begin
            e = q.pop_front();
            chk("sum", sum, e.s);
            chk("cout", cout, e.c);
            chk("ovf", ovf, e.o);
            if (e.lat) chk("latency", cyc - e.acc, 3);
          end
        end
      end
      prev_stall = !rst && out_valid && !out_ready;
      ps = sum; pc = cout; po = ovf;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[11];
    exp_t        e;
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [4:0]  f4;
    logic [3:0]  es4;
    logic        ec4, eo4;

    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[3]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[4]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[5]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[7]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[9]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vt[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
    out_ready = 1'b1;
    n1_in_valid = 1'b0; n1_a = '0; n1_b = '0; n1_cin = 1'b0; n1_sub = 1'b0;

    // Reset held two cycles with operands presented.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_n1_valid", n1_out_valid, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1'b0);
    end
    chk("post_rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed vectors streamed back-to-back.
    for (int i = 0; i < 11; i++) begin
      e.s = vt[i].s; e.c = vt[i].c; e.o = vt[i].o; e.acc = 0; e.lat = 1'b1;
      send(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, e);
    end
    drain();

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = 16'($urandom); rb = 16'($urandom);
          rc = 1'($urandom);  rs = 1'($urandom);
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_seen", saw_bp, 1'b1);

    // Reset before the first of three in-flight results emerges.
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
    end
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_sum", sum, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    e.s = 16'h2346; e.c = 1'b0; e.o = 1'b0; e.acc = 0; e.lat = 1'b1;
    send(16'h1234, 16'h1111, 1'b1, 1'b0, e);
    drain();

    // Single-stage instance: result registered once, visible after acceptance edge.
    for (int i = 0; i < 42; i++) begin
      if (i == 0) begin
        n1_a = 4'hF; n1_b = 4'h1; n1_cin = 1'b0; n1_sub = 1'b0;
      end else if (i == 1) begin
        n1_a = 4'h7; n1_b = 4'h1; n1_cin = 1'b0; n1_sub = 1'b0;
      end else begin
        n1_a = 4'($urandom); n1_b = 4'($urandom);
        n1_cin = 1'($urandom); n1_sub = 1'($urandom);
      end
      if (n1_sub) begin
        es4 = n1_a - n1_b;
        ec4 = (n1_a >= n1_b);
        eo4 = (n1_a[3] != n1_b[3]) && (es4[3] != n1_a[3]);
      end else begin
        f4  = {1'b0, n1_a} + {1'b0, n1_b} + {4'b0, n1_cin};
        es4 = f4[3:0];
        ec4 = f4[4];
        eo4 = (n1_a[3] == n1_b[3]) && (es4[3] != n1_a[3]);
      end
      n1_in_valid = 1'b1;
      @(negedge clk);
      chk("n1_in_ready", n1_in_ready, 1'b1);
      @(posedge clk);
      #1;
      chk("n1_valid", n1_out_valid, 1'b1);
      chk("n1_sum", n1_sum, es4);
      chk("n1_cout", n1_cout, ec4);
      chk("n1_ovf", n1_ovf, eo4);
    end
    n1_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("n1_idle_valid", n1_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
